mapper_result_collector: RTL

Upstream counterpart of the mapper stream distributor: merges the result streams of NUM_MAPPERS mapper instances into the single stream toward the PCIe transmit path. The collector arbitrates round-robin at packet granularity. A grant, once made, is held until the granted mapper's last beat has been accepted, so packets are never interleaved. A one-entry registered output stage decouples mapper data from the PCIe side. A packet counter supports host-side accounting.

---
 rtl/mapper_result_collector.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mapper_result_collector.sv
// Merges NUM_MAPPERS mapper result streams into one PCIe TX stream.
// Round-robin grant at packet granularity, one-entry registered output stage.
module mapper_result_collector #(
    parameter int NUM_MAPPERS = 2,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_MAPPERS-1:0]            i_mapper_valid,
    input  logic [NUM_MAPPERS*DATA_WIDTH-1:0] i_mapper_data,
    input  logic [NUM_MAPPERS-1:0]            i_mapper_last,
    output logic [NUM_MAPPERS-1:0]            o_mapper_rdy,
    output logic                              o_pcie_strm_valid,
    output logic [DATA_WIDTH-1:0]             o_pcie_strm_data,
    output logic                              o_pcie_strm_last,
    input  logic                              i_pcie_strm_rdy,
    output logic [$clog2(NUM_MAPPERS)-1:0]    o_active_mapper,
    output logic [31:0]                       o_pkt_count
);

    localparam int IDX_W = $clog2(NUM_MAPPERS);

    // Handshake: a beat moves on either side only when valid and rdy are both
    // high at the rising edge; valid must not wait on rdy.
    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_XFER   = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       ptr_d;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_last_q;
    logic [31:0]            pkt_count_q;
    logic [31:0]            pkt_count_d;

    logic                   found;
    logic [IDX_W-1:0]       found_idx;
    logic [IDX_W:0]         scan_sum;
    logic                   grant_rdy;
    logic                   accept;
    logic                   pcie_hs;
    logic [DATA_WIDTH-1:0]  beat_data;
    logic                   beat_last;

    // Scan ptr, ptr+1, ... modulo NUM_MAPPERS; the extra sum bit keeps the
    // wrap correct for non-power-of-2 mapper counts.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        scan_sum  = '0;
        for (int i = 0; i < NUM_MAPPERS; i++) begin
            scan_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (scan_sum >= (IDX_W+1)'(NUM_MAPPERS)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NUM_MAPPERS);
            end
            if (!found && i_mapper_valid[scan_sum[IDX_W-1:0]]) begin
                found     = 1'b1;
                found_idx = scan_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grant_rdy    = (state_q == ST_XFER) && (!out_valid_q || i_pcie_strm_rdy);
        o_mapper_rdy = '0;
        if (grant_rdy) begin
            o_mapper_rdy[grant_q] = 1'b1;
        end
        beat_data   = i_mapper_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        beat_last   = i_mapper_last[grant_q];
        accept      = grant_rdy && i_mapper_valid[grant_q];
        pcie_hs     = out_valid_q && i_pcie_strm_rdy;
        ptr_d       = (grant_q == IDX_W'(NUM_MAPPERS-1)) ? '0 : grant_q + 1'b1;
        pkt_count_d = pkt_count_q + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_SEARCH;
            grant_q     <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (found) begin
                        grant_q <= found_idx;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept && beat_last) begin
                        ptr_q   <= ptr_d;
                        state_q <= ST_SEARCH;
                    end
                end
                default: state_q <= ST_SEARCH;
            endcase

            // A new beat overwrites a beat leaving in the same cycle.
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= beat_data;
                out_last_q  <= beat_last;
            end else if (pcie_hs) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_last_q  <= 1'b0;
            end

            if (pcie_hs && out_last_q) begin
                pkt_count_q <= pkt_count_d;
            end
        end
    end

    assign o_pcie_strm_valid = out_valid_q;
    assign o_pcie_strm_data  = out_data_q;
    assign o_pcie_strm_last  = out_last_q;
    assign o_active_mapper   = grant_q;
    assign o_pkt_count       = pkt_count_q;

endmodule
